// File: rtl/spectrum_bar_render_pkg.sv
// Shared video definitions for the HDMI pixel path: colour type, default palette
// and the active raster size used by the sync generator.
package spectrum_bar_render_pkg;

    typedef logic [23:0] rgb_t;

    localparam int unsigned V_ACT_DEF = 720;
    localparam int unsigned H_ACT_DEF = 1280;

    localparam rgb_t BAR_COLOR_DEF = 24'h00C040;
    localparam rgb_t CAP_COLOR_DEF = 24'hFFFF00;
    localparam rgb_t BG_COLOR_DEF  = 24'h000000;

endpackage

// File: rtl/spectrum_bin_ram_dp.sv
// Simple dual-port bin memory: one write port, one registered read port.
// Storage is not reset; only the read register is.
module spectrum_bin_ram_dp #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_bar_render.sv
// Draws one vertical bar per FFT bin on the active raster. Bins are double-buffered
// and the banks swap only on a vs rising edge so a frame never mixes two spectra.
module spectrum_bar_render
    import spectrum_bar_render_pkg::*;
#(
    parameter int unsigned Y_BITS    = 12,
    parameter int unsigned V_ACT     = V_ACT_DEF,
    parameter int unsigned BIN_NUM   = 256,
    parameter int unsigned BIN_AW    = 8,
    parameter int unsigned MAG_W     = 10,
    parameter int unsigned BAR_W     = 5,
    parameter int unsigned BAR_GAP   = 1,
    parameter int unsigned CAP_H     = 8,
    parameter rgb_t        BAR_COLOR = BAR_COLOR_DEF,
    parameter rgb_t        CAP_COLOR = CAP_COLOR_DEF,
    parameter rgb_t        BG_COLOR  = BG_COLOR_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              bin_wr_en,
    input  logic [BIN_AW-1:0] bin_wr_addr,
    input  logic [MAG_W-1:0]  bin_wr_data,
    input  logic              bin_frame_done,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [Y_BITS-1:0] y_act,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out
);

    localparam int unsigned COL_W = $clog2(BAR_W + 1);
    localparam int unsigned HW    = Y_BITS + 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BAR_W - 1);
    localparam logic [COL_W-1:0]  COL_LIT  = COL_W'(BAR_W - BAR_GAP);
    localparam logic [BIN_AW:0]   BIN_END  = (BIN_AW + 1)'(BIN_NUM);
    localparam logic [HW-1:0]     V_LIM    = HW'(V_ACT);
    localparam logic [HW-1:0]     CAP_ROWS = HW'(CAP_H);

    // Bank control: bank_sel names the front bank, the other one takes writes.
    logic vs_q, bank_sel, swap_pend, swap;

    assign swap = vs_in & ~vs_q & (swap_pend | bin_frame_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q      <= 1'b0;
            bank_sel  <= 1'b0;
            swap_pend <= 1'b0;
        end else begin
            vs_q <= vs_in;
            if (swap) begin
                bank_sel  <= ~bank_sel;
                swap_pend <= 1'b0;
            end else if (bin_frame_done) begin
                swap_pend <= 1'b1;
            end
        end
    end

    // Column tracking; bin_idx sticks at BIN_END past the last slot.
    logic [COL_W-1:0] col_cnt, col_d;
    logic [BIN_AW:0]  bin_idx, bin_d;

    always_comb begin
        col_d = '0;
        bin_d = '0;
        if (de_in) begin
            if (col_cnt == COL_LAST) begin
                col_d = '0;
                bin_d = (bin_idx == BIN_END) ? bin_idx : bin_idx + (BIN_AW + 1)'(1);
            end else begin
                col_d = col_cnt + COL_W'(1);
                bin_d = bin_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_cnt <= '0;
            bin_idx <= '0;
        end else begin
            col_cnt <= col_d;
            bin_idx <= bin_d;
        end
    end

    logic [MAG_W-1:0] rd0, rd1;

    spectrum_bin_ram_dp #(.AW(BIN_AW), .DW(MAG_W)) u_bank0 (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (bin_wr_en & bank_sel),
        .wr_addr (bin_wr_addr),
        .wr_data (bin_wr_data),
        .rd_addr (bin_idx[BIN_AW-1:0]),
        .rd_data (rd0)
    );

    spectrum_bin_ram_dp #(.AW(BIN_AW), .DW(MAG_W)) u_bank1 (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (bin_wr_en & ~bank_sel),
        .wr_addr (bin_wr_addr),
        .wr_data (bin_wr_data),
        .rd_addr (bin_idx[BIN_AW-1:0]),
        .rd_data (rd1)
    );

    // S1: registered position/timing alongside the bank read.
    logic [COL_W-1:0]  col_s1;
    logic [BIN_AW:0]   bin_s1;
    logic [Y_BITS-1:0] y_s1;
    logic              de_s1, vs_s1, hs_s1, sel_s1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_s1 <= '0;
            bin_s1 <= '0;
            y_s1   <= '0;
            de_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            hs_s1  <= 1'b0;
            sel_s1 <= 1'b0;
        end else begin
            col_s1 <= col_cnt;
            bin_s1 <= bin_idx;
            y_s1   <= y_act;
            de_s1  <= de_in;
            vs_s1  <= vs_in;
            hs_s1  <= hs_in;
            sel_s1 <= bank_sel;
        end
    end

    // S2: height compare and colour select.
    logic [HW-1:0] mag_ext, h, y_ext;
    logic          lit, cap;
    rgb_t          pix_d, pix_s2, pix_s3;
    logic          de_s2, vs_s2, hs_s2;

    always_comb begin
        mag_ext = HW'(sel_s1 ? rd1 : rd0);
        h       = (mag_ext > V_LIM) ? V_LIM : mag_ext;
        y_ext   = HW'(y_s1);
        lit     = (y_ext + h >= V_LIM) && (col_s1 < COL_LIT) && (bin_s1 < BIN_END);
        cap     = y_ext < (V_LIM - h + CAP_ROWS);
        pix_d   = '0;
        if (de_s1) begin
            pix_d = !lit ? BG_COLOR : (cap ? CAP_COLOR : BAR_COLOR);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_s2 <= '0;
            de_s2  <= 1'b0;
            vs_s2  <= 1'b0;
            hs_s2  <= 1'b0;
            pix_s3 <= '0;
            de_out <= 1'b0;
            vs_out <= 1'b0;
            hs_out <= 1'b0;
        end else begin
            pix_s2 <= pix_d;
            de_s2  <= de_s1;
            vs_s2  <= vs_s1;
            hs_s2  <= hs_s1;
            pix_s3 <= pix_s2;
            de_out <= de_s2;
            vs_out <= vs_s2;
            hs_out <= hs_s2;
        end
    end

    assign r_out = pix_s3[23:16];
    assign g_out = pix_s3[15:8];
    assign b_out = pix_s3[7:0];

endmodule

// File: tb/tb_spectrum_bar_render.sv
// Directed bench for spectrum_bar_render: bank swapping, bar/cap geometry,
// pipeline alignment and mid-line reset.
module tb_spectrum_bar_render;

    localparam logic [31:0] BAR = 32'h0000C040;
    localparam logic [31:0] CAP = 32'h00FFFF00;
    localparam logic [31:0] BG  = 32'h00000000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bin_wr_en = 1'b0;
    logic [7:0]  bin_wr_addr = '0;
    logic [9:0]  bin_wr_data = '0;
    logic        bin_frame_done = 1'b0;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [11:0] y_act = '0;
    logic        vs_out, hs_out, de_out;
    logic [7:0]  r_out, g_out, b_out;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [23:0] cap [1300];
    int          cap_n = 0;

    always #5 clk = ~clk;

    spectrum_bar_render dut (
        .clk            (clk),
        .rstn           (rstn),
        .bin_wr_en      (bin_wr_en),
        .bin_wr_addr    (bin_wr_addr),
        .bin_wr_data    (bin_wr_data),
        .bin_frame_done (bin_frame_done),
        .vs_in          (vs_in),
        .hs_in          (hs_in),
        .de_in          (de_in),
        .y_act          (y_act),
        .vs_out         (vs_out),
        .hs_out         (hs_out),
        .de_out         (de_out),
        .r_out          (r_out),
        .g_out          (g_out),
        .b_out          (b_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        bin_wr_en   = 1'b1;
        bin_wr_addr = 8'(addr);
        bin_wr_data = 10'(data);
        step();
        bin_wr_en   = 1'b0;
    endtask

    task automatic done_pulse();
        bin_frame_done = 1'b1;
        step();
        bin_frame_done = 1'b0;
    endtask

    // vs pulse; optionally done and/or a write land in the rising-edge cycle.
    task automatic vs_edge(input bit with_done, input bit with_wr, input int addr, input int data);
        vs_in          = 1'b1;
        bin_frame_done = with_done;
        bin_wr_en      = with_wr;
        bin_wr_addr    = 8'(addr);
        bin_wr_data    = 10'(data);
        step();
        bin_frame_done = 1'b0;
        bin_wr_en      = 1'b0;
        step();
        vs_in = 1'b0;
        repeat (2) step();
    endtask

    task automatic draw_line(input int y, input int ncols);
        cap_n = 0;
        hs_in = 1'b1;
        repeat (2) step();
        hs_in = 1'b0;
        repeat (2) step();
        y_act = 12'(y);
        de_in = 1'b1;
        repeat (ncols) step();
        de_in = 1'b0;
        y_act = '0;
        repeat (6) step();
    endtask

    function automatic logic [31:0] px(input int x);
        return {8'h00, cap[x]};
    endfunction

    function automatic int count_lit();
        int n = 0;
        for (int i = 0; i < cap_n && i < 1300; i++) begin
            if (cap[i] != 24'h0) n++;
        end
        return n;
    endfunction

    // Output capture while de_out is high.
    initial begin
        forever begin
            @(negedge clk);
            if (de_out) begin
                if (cap_n < 1300) cap[cap_n] = {r_out, g_out, b_out};
                cap_n++;
            end
        end
    end

    // Timing outputs must trail the inputs by exactly three cycles; blanking is black.
    initial begin
        logic [2:0] h1, h2, h3;
        h1 = '0;
        h2 = '0;
        h3 = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("sync_delay", {29'h0, vs_out, hs_out, de_out}, {29'h0, h3});
                if (!de_out) check("blank_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
            end
            h3 = h2;
            h2 = h1;
            h1 = {vs_in, hs_in, de_in};
        end
    end

    initial begin
        #3;
        check("reset_out", {8'h0, vs_out, hs_out, de_out, 5'h0, r_out, g_out, b_out}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) step();
        mon_en = 1'b1;

        // Zero both banks so nothing depends on uninitialised memory.
        for (int i = 0; i < 256; i++) wr(i, 0);
        done_pulse();
        vs_edge(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 256; i++) wr(i, 0);
        done_pulse();
        vs_edge(1'b0, 1'b0, 0, 0);

        // Back-bank write and done without a vs edge: display unchanged.
        wr(0, 100);
        done_pulse();
        draw_line(650, 1280);
        check("noswap_len", 32'(cap_n), 32'd1280);
        check("noswap_lit", 32'(count_lit()), 32'd0);

        vs_edge(1'b0, 1'b0, 0, 0);
        draw_line(650, 1280);
        check("b0_y650_c0", px(0), BAR);
        check("b0_y650_c3", px(3), BAR);
        check("b0_y650_c4", px(4), BG);
        check("b0_y650_c5", px(5), BG);
        check("b0_y650_lit", 32'(count_lit()), 32'd4);
        draw_line(619, 1280);
        check("b0_y619_c0", px(0), BG);
        draw_line(620, 1280);
        check("b0_y620_c0", px(0), CAP);
        draw_line(627, 1280);
        check("b0_y627_c2", px(2), CAP);
        draw_line(628, 1280);
        check("b0_y628_c0", px(0), BAR);
        draw_line(719, 1280);
        check("b0_y719_c3", px(3), BAR);

        // Done coincident with the vs rising edge swaps on that edge.
        wr(255, 1023);
        vs_edge(1'b1, 1'b0, 0, 0);
        draw_line(0, 1280);
        check("b255_y0_c1275", px(1275), CAP);
        check("b255_y0_c1278", px(1278), CAP);
        check("b255_y0_c1279", px(1279), BG);
        check("b255_y0_c1274", px(1274), BG);
        check("b255_y0_c0", px(0), BG);
        check("b255_y0_lit", 32'(count_lit()), 32'd4);
        draw_line(7, 1280);
        check("b255_y7_c1276", px(1276), CAP);
        draw_line(8, 1280);
        check("b255_y8_c1276", px(1276), BAR);
        draw_line(719, 1290);
        check("b255_y719_c1275", px(1275), BAR);
        check("b255_y719_c1279", px(1279), BG);
        check("sat_len", 32'(cap_n), 32'd1290);
        check("sat_c1280", px(1280), BG);
        check("sat_c1285", px(1285), BG);
        check("sat_lit", 32'(count_lit()), 32'd4);

        // A write in the swap cycle lands in the pre-swap back bank.
        wr(2, 719);
        done_pulse();
        vs_edge(1'b0, 1'b1, 1, 720);
        draw_line(0, 1280);
        check("swpwr_y0_c5", px(5), CAP);
        check("swpwr_y0_c0", px(0), BG);
        check("swpwr_y0_c10", px(10), BG);
        check("swpwr_y0_c1275", px(1275), BG);
        draw_line(1, 1280);
        check("swpwr_y1_c10", px(10), CAP);
        draw_line(8, 1280);
        check("swpwr_y8_c5", px(5), BAR);
        check("swpwr_y8_c10", px(10), CAP);
        draw_line(9, 1280);
        check("swpwr_y9_c10", px(10), BAR);

        // Repeated done is a single pending swap.
        done_pulse();
        done_pulse();
        vs_edge(1'b0, 1'b0, 0, 0);
        vs_edge(1'b0, 1'b0, 0, 0);
        draw_line(0, 1280);
        check("dbl_y0_c1275", px(1275), CAP);
        check("dbl_y0_c5", px(5), BG);

        // Mid-line reset: switch front to bank 1, leave a swap pending, then reset.
        done_pulse();
        vs_edge(1'b0, 1'b0, 0, 0);
        done_pulse();
        hs_in = 1'b1;
        repeat (2) step();
        hs_in = 1'b0;
        y_act = 12'd100;
        de_in = 1'b1;
        repeat (300) step();
        @(negedge clk);
        check("pre_rst_de", {31'h0, de_out}, 32'h1);
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_out", {8'h0, vs_out, hs_out, de_out, 5'h0, r_out, g_out, b_out}, 32'h0);
        de_in = 1'b0;
        y_act = '0;
        repeat (3) step();
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) step();
        mon_en = 1'b1;
        vs_edge(1'b0, 1'b0, 0, 0);
        draw_line(0, 1280);
        check("post_rst_c1275", px(1275), CAP);
        check("post_rst_c5", px(5), BG);
        check("post_rst_lit", 32'(count_lit()), 32'd4);

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
